dac_interface_apb: RTL and testbench

//  APB slave that drives a 10-bit DAC, the output-direction counterpart of the ADC APB interface.
//  An APB write to the DATA register latches a code, pulses START to the DAC, and waits for the
//  DAC BUSY handshake to complete. PREADY is withheld until the DAC has accepted the code.

---
 rtl/dac_interface_apb.sv | 148 ++++++++++++++
 tb/tb_dac_interface_apb.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/dac_interface_apb.sv
`default_nettype none
// ============================================================================
// Module      : dac_interface_apb
// Description : APB slave that latches a DAC code, pulses START and holds
//               PREADY until the DAC BUSY handshake completes.
// Revision    : 1.0 - initial release
// ============================================================================
module dac_interface_apb #(
  parameter int DATA_W  = 10,
  parameter int TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [31:0]       PADDR,
  input  logic [31:0]       PWDATA,
  input  logic [3:0]        PSTRB,
  output logic              PREADY,
  output logic [31:0]       PRDATA,
  output logic              PSLVERR,
  output logic [DATA_W-1:0] DATA,
  output logic              START,
  input  logic              BUSY
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_WAIT_HI = 3'd2,
    S_WAIT_LO = 3'd3,
    S_ACK     = 3'd4,
    S_ERR_ACK = 3'd5,
    S_RD_ACK  = 3'd6
  } state_t;

  localparam logic [7:0] c_TO_LAST = 8'(TIMEOUT - 1);

  state_t            r_state;
  state_t            w_next;
  logic [DATA_W-1:0] r_code;
  logic              r_err;
  logic [7:0]        r_cnt;
  logic [31:0]       r_prdata;
  logic [31:0]       w_rd_data;
  logic [15:0]       w_mask;
  logic [15:0]       w_merged16;
  logic              w_access;
  logic              w_busy_fsm;
  logic              w_load_code;
  logic              w_set_err;
  logic              w_clr_err;
  logic              w_clr_cnt;
  logic              w_inc_cnt;
  logic              w_unused;

  assign w_access   = PSEL & PENABLE;
  assign w_busy_fsm = (r_state == S_START) | (r_state == S_WAIT_HI) | (r_state == S_WAIT_LO);

  // Byte-strobe merge: unstrobed bytes keep the previously latched code.
  assign w_mask     = {{8{PSTRB[1]}}, {8{PSTRB[0]}}};
  assign w_merged16 = (16'(r_code) & ~w_mask) | (PWDATA[15:0] & w_mask);
  assign w_rd_data  = PADDR[2] ? {29'b0, r_err, w_busy_fsm, BUSY} : 32'(r_code);
  assign w_unused   = ^{PADDR[31:4], PADDR[1:0], PWDATA[31:16], PSTRB[3:2], w_merged16};

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_load_code = 1'b0;
    w_set_err   = 1'b0;
    w_clr_err   = 1'b0;
    w_clr_cnt   = 1'b0;
    w_inc_cnt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_access) begin
          if (PADDR[3]) begin
            w_next = S_ERR_ACK;
          end else if (!PWRITE) begin
            w_next = S_RD_ACK;
          end else if (PADDR[2]) begin
            w_clr_err = PWDATA[0];
            w_next    = S_ACK;
          end else begin
            w_load_code = 1'b1;
            w_next      = S_START;
          end
        end
      end
      S_START: begin
        w_clr_cnt = 1'b1;
        w_next    = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (BUSY) begin
          w_clr_cnt = 1'b1;
          w_next    = S_WAIT_LO;
        end else if (r_cnt == c_TO_LAST) begin
          w_set_err = 1'b1;
          w_next    = S_ERR_ACK;
        end else begin
          w_inc_cnt = 1'b1;
        end
      end
      S_WAIT_LO: begin
        if (!BUSY) begin
          w_next = S_ACK;
        end else if (r_cnt == c_TO_LAST) begin
          w_set_err = 1'b1;
          w_next    = S_ERR_ACK;
        end else begin
          w_inc_cnt = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_code   <= '0;
      r_err    <= 1'b0;
      r_cnt    <= 8'd0;
      r_prdata <= 32'd0;
    end else begin
      if (w_load_code) r_code <= w_merged16[DATA_W-1:0];
      if (w_set_err)      r_err <= 1'b1;
      else if (w_clr_err) r_err <= 1'b0;
      if (w_clr_cnt)      r_cnt <= 8'd0;
      else if (w_inc_cnt) r_cnt <= r_cnt + 8'd1;
      // Read data exists only for the single RD_ACK cycle, zero otherwise.
      r_prdata <= (w_next == S_RD_ACK) ? w_rd_data : 32'd0;
    end
  end

  assign DATA    = r_code;
  assign START   = (r_state == S_START);
  assign PREADY  = (r_state == S_ACK) | (r_state == S_ERR_ACK) | (r_state == S_RD_ACK);
  assign PSLVERR = (r_state == S_ERR_ACK);
  assign PRDATA  = r_prdata;

endmodule
`default_nettype wire

// File: tb/tb_dac_interface_apb.sv
`default_nettype none
// ============================================================================
// Module      : tb_dac_interface_apb
// Description : Randomized APB/DAC-handshake bench with a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dac_interface_apb;

  localparam int DW = 10;
  localparam int TO = 16;

  logic          CLK     = 1'b0;
  logic          RST     = 1'b1;
  logic          PSEL    = 1'b0;
  logic          PENABLE = 1'b0;
  logic          PWRITE  = 1'b0;
  logic [31:0]   PADDR   = 32'd0;
  logic [31:0]   PWDATA  = 32'd0;
  logic [3:0]    PSTRB   = 4'd0;
  logic          BUSY    = 1'b0;
  logic          PREADY;
  logic [31:0]   PRDATA;
  logic          PSLVERR;
  logic [DW-1:0] DATA;
  logic          START;

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [DW-1:0] m_code  = '0;
  logic          m_err   = 1'b0;

  dac_interface_apb #(.DATA_W(DW), .TIMEOUT(TO)) u_dut (
    .CLK(CLK), .RST(RST), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PREADY(PREADY),
    .PRDATA(PRDATA), .PSLVERR(PSLVERR), .DATA(DATA), .START(START), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // DAC behaviour: BUSY high during cycles [d, d+h) counted from the START cycle.
  function automatic bit busy_at(input int k, input int d, input int h);
    return (k >= d) && (k < d + h);
  endfunction

  task automatic apb_setup(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb, input logic bsy);
    @(negedge CLK);
    check("idle_pready", PREADY, 1'b0);
    check("idle_prdata", PRDATA, 32'd0);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
    PSTRB = strb; BUSY = bsy;
    @(negedge CLK);
    check("setup_start", START, 1'b0);
    PENABLE = 1'b1;
  endtask

  task automatic apb_write(input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb, input int d, input int h);
    int            f;
    int            rise;
    int            e;
    bit            perr;
    bit            is_data;
    logic [DW-1:0] exp_code;
    f = 0; perr = 1'b0; exp_code = m_code;
    is_data = (addr[3:2] == 2'd0);
    if (is_data) begin
      if (strb[0]) exp_code[7:0]    = wdata[7:0];
      if (strb[1]) exp_code[DW-1:8] = wdata[DW-1:8];
      // WAIT_HI entered one edge after the sampling edge; BUSY seen at edge e is busy_at(e-1).
      rise = -1; f = -1; e = 2;
      while (f < 0 && rise < 0) begin
        if (busy_at(e - 1, d, h))  rise = e;
        else if (e - 1 >= TO) begin f = e; perr = 1'b1; end
        e++;
      end
      if (rise >= 0) begin
        e = rise + 1;
        while (f < 0) begin
          if (!busy_at(e - 1, d, h)) f = e;
          else if (e - rise >= TO) begin f = e; perr = 1'b1; end
          e++;
        end
      end
    end else if (addr[3:2] != 2'd1) begin
      perr = 1'b1;
    end
    apb_setup(1'b1, addr, wdata, strb, 1'b0);
    for (int j = 0; j <= f; j++) begin
      @(negedge CLK);
      check("w_start",   START,   (j == 0) && is_data);
      check("w_pready",  PREADY,  j == f);
      check("w_pslverr", PSLVERR, (j == f) && perr);
      check("w_prdata",  PRDATA,  32'd0);
      if (j == f) begin
        check("w_data", DATA, exp_code);
        PSEL = 1'b0; PENABLE = 1'b0;
      end
      BUSY = is_data ? busy_at(j, d, h) : 1'b0;
    end
    m_code = exp_code;
    if (is_data && perr)                      m_err = 1'b1;
    if (addr[3:2] == 2'd1 && wdata[0])        m_err = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] addr, input logic bsy);
    logic [31:0] exp;
    bit          perr;
    perr = addr[3];
    case (addr[3:2])
      2'd0:    exp = 32'(m_code);
      2'd1:    exp = {29'd0, m_err, 1'b0, bsy};
      default: exp = 32'd0;
    endcase
    apb_setup(1'b0, addr, 32'd0, 4'd0, bsy);
    check("r_prdata_pre", PRDATA, 32'd0);
    @(negedge CLK);
    check("r_pready",  PREADY,  1'b1);
    check("r_pslverr", PSLVERR, perr);
    check("r_prdata",  PRDATA,  exp);
    check("r_start",   START,   1'b0);
    check("r_data",    DATA,    m_code);
    PSEL = 1'b0; PENABLE = 1'b0; BUSY = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 RST = 1'b0;
    #1;
    check("rst_data",   DATA,    '0);
    check("rst_start",  START,   1'b0);
    check("rst_pready", PREADY,  1'b0);
    check("rst_slverr", PSLVERR, 1'b0);
    check("rst_prdata", PRDATA,  32'd0);
    repeat (3) @(negedge CLK);
    RST = 1'b1;

    // T1/T2: strobed writes with a well-behaved DAC
    apb_write(32'h0, 32'h3A5, 4'b0011, 2, 5);
    apb_write(32'h0, 32'h0FF, 4'b0001, 1, 1);
    apb_write(32'h0, 32'h000, 4'b0000, 3, 2);
    // T3: DAC never answers -> timeout error; then clear the flag
    apb_write(32'h0, 32'h155, 4'b0000, 200, 1);
    apb_read(32'h4, 1'b0);
    apb_write(32'h4, 32'h1, 4'hF, 0, 0);
    apb_read(32'h4, 1'b0);
    // T4: readback and unmapped accesses
    apb_read(32'h0, 1'b0);
    apb_read(32'h8, 1'b0);
    apb_write(32'h8, 32'h2A, 4'hF, 0, 0);
    apb_write(32'h0, 32'h001, 4'b0011, 1, 200);
    apb_write(32'hC, 32'h0, 4'hF, 0, 0);
    apb_read(32'h4, 1'b1);

    // T5: reset while waiting for BUSY to fall
    apb_setup(1'b1, 32'h0, 32'h2AA, 4'b0011, 1'b0);
    for (int j = 0; j <= 3; j++) begin
      @(negedge CLK);
      BUSY = busy_at(j, 1, 100);
    end
    check("t5_data_pre", DATA, 10'h2AA);
    RST = 1'b0;
    #1;
    check("t5_data",    DATA,    '0);
    check("t5_start",   START,   1'b0);
    check("t5_pready",  PREADY,  1'b0);
    check("t5_slverr",  PSLVERR, 1'b0);
    check("t5_prdata",  PRDATA,  32'd0);
    PSEL = 1'b0; PENABLE = 1'b0; BUSY = 1'b0;
    m_code = '0; m_err = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    check("t5_noreplay_start", START, 1'b0);
    check("t5_noreplay_ready", PREADY, 1'b0);
    apb_write(32'h0, 32'h001, 4'b0011, 1, 2);
    apb_read(32'h0, 1'b0);

    // T6: back-to-back writes with random BUSY timing
    apb_write(32'h0, 32'h100, 4'b0011, $urandom_range(0, 6), $urandom_range(1, 6));
    apb_write(32'h0, 32'h200, 4'b0011, $urandom_range(0, 6), $urandom_range(1, 6));
    apb_read(32'h0, 1'b0);

    // Random mix of all access types, including both timeout phases
    for (int n = 0; n < 40; n++) begin
      int d;
      int h;
      d = $urandom_range(0, 20);
      h = $urandom_range(1, 20);
      if ($urandom_range(0, 7) == 0) d = 200;
      if ($urandom_range(0, 7) == 0) h = 200;
      case ($urandom_range(0, 5))
        0, 1: apb_write(32'h0, $urandom, 4'($urandom), d, h);
        2:    apb_write(32'h4, $urandom, 4'hF, 0, 0);
        3:    apb_read(32'h0, 1'($urandom));
        4:    apb_read(32'h4, 1'($urandom));
        default: begin
          if ($urandom_range(0, 1) == 0) apb_read({28'd0, 2'($urandom_range(2, 3)), 2'd0}, 1'b0);
          else apb_write({28'd0, 2'($urandom_range(2, 3)), 2'd0}, $urandom, 4'hF, 0, 0);
        end
      endcase
    end
    apb_read(32'h4, 1'b0);
    @(negedge CLK);
    check("end_pready", PREADY, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
